// File: rtl/io_port_hub.sv
// Responder side of the processor I/O bus. It services input pops from per-channel FIFOs
// and output writes into per-channel holding registers, and drives the core's itr line.
module io_port_hub #(
    parameter int unsigned       NUBITS = 16,
    parameter int unsigned       NUIOIN = 2,
    parameter int unsigned       NUIOOU = 2,
    parameter int unsigned       FDEPTH = 4,
    parameter logic [NUIOIN-1:0] ITRMSK = {NUIOIN{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_in,
    input  logic [$clog2(NUIOIN)-1:0]   addr_in,
    output logic [NUBITS-1:0]           io_in,
    input  logic                        out_en,
    input  logic [$clog2(NUIOOU)-1:0]   addr_out,
    input  logic [NUBITS-1:0]           io_out,
    output logic                        itr,
    input  logic [NUIOIN*NUBITS-1:0]    s_data,
    input  logic [NUIOIN-1:0]           s_valid,
    output logic [NUIOIN-1:0]           s_ready,
    output logic [NUIOOU*NUBITS-1:0]    m_data,
    output logic [NUIOOU-1:0]           m_valid,
    input  logic [NUIOOU-1:0]           m_ready,
    output logic [NUIOIN-1:0]           unf,
    output logic [NUIOOU-1:0]           ovf
);

    localparam int unsigned AIW = $clog2(NUIOIN);
    localparam int unsigned AOW = $clog2(NUIOOU);
    localparam int unsigned PW  = $clog2(FDEPTH);
    localparam int unsigned CW  = PW + 1;

    logic [NUIOIN-1:0][CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [NUIOIN-1:0][CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [NUBITS-1:0]             mem_q [NUIOIN][FDEPTH];
    logic [NUIOIN-1:0][NUBITS-1:0] head;
    logic [NUIOIN-1:0]             empty, full, push, pop, req_sel;
    logic [NUIOIN-1:0]             unf_q, unf_d;
    logic                          itr_q, itr_d;

    logic [NUIOOU-1:0][NUBITS-1:0] m_data_q, m_data_d;
    logic [NUIOOU-1:0]             m_valid_q, m_valid_d;
    logic [NUIOOU-1:0]             ovf_q, ovf_d;

    // FIFO status and per-channel push/pop decode; full uses the wrap bit to tell full from empty
    always_comb begin
        empty   = '0;
        full    = '0;
        push    = '0;
        pop     = '0;
        req_sel = '0;
        head    = '0;
        for (int k = 0; k < int'(NUIOIN); k++) begin
            empty[k]   = (wr_ptr_q[k] == rd_ptr_q[k]);
            full[k]    = (wr_ptr_q[k][PW] != rd_ptr_q[k][PW]) &&
                         (wr_ptr_q[k][PW-1:0] == rd_ptr_q[k][PW-1:0]);
            req_sel[k] = req_in && (addr_in == AIW'(k));
            push[k]    = s_valid[k] && !full[k];
            pop[k]     = req_sel[k] && !empty[k];
            head[k]    = mem_q[k][rd_ptr_q[k][PW-1:0]];
        end
    end

    // Pointer, underflow and interrupt next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        unf_d    = unf_q | (req_sel & empty);
        itr_d    = |(~empty & ITRMSK);
        for (int k = 0; k < int'(NUIOIN); k++) begin
            wr_ptr_d[k] = wr_ptr_q[k] + CW'(push[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + CW'(pop[k]);
        end
    end

    // Storage carries no reset: emptiness is defined by the pointers alone
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUIOIN); k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k][PW-1:0]] <= s_data[k*NUBITS +: NUBITS];
            end
        end
    end

    // Zero-latency read mux; out-of-range addresses match no channel and return 0
    always_comb begin
        io_in = '0;
        for (int k = 0; k < int'(NUIOIN); k++) begin
            if ((addr_in == AIW'(k)) && !empty[k]) begin
                io_in = head[k];
            end
        end
    end

    // Output holding registers: load when empty or draining this cycle, else drop and flag
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        ovf_d     = ovf_q;
        for (int j = 0; j < int'(NUIOOU); j++) begin
            if (out_en && (addr_out == AOW'(j))) begin
                if (!m_valid_q[j] || m_ready[j]) begin
                    m_data_d[j]  = io_out;
                    m_valid_d[j] = 1'b1;
                end else begin
                    ovf_d[j] = 1'b1;
                end
            end else if (m_valid_q[j] && m_ready[j]) begin
                m_valid_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            unf_q     <= '0;
            itr_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= '0;
            ovf_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            unf_q     <= unf_d;
            itr_q     <= itr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign s_ready = ~full;
    assign itr     = itr_q;
    assign unf     = unf_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_io_port_hub.sv
// Vector bench for io_port_hub: each record is driven after a falling edge and the
// outputs visible in that cycle are compared before the next rising edge.
module tb_io_port_hub;

    logic        clk;
    logic        rst;
    logic        req_in;
    logic [0:0]  addr_in;
    logic [15:0] io_in;
    logic        out_en;
    logic [0:0]  addr_out;
    logic [15:0] io_out;
    logic        itr;
    logic [31:0] s_data;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [31:0] m_data;
    logic [1:0]  m_valid;
    logic [1:0]  m_ready;
    logic [1:0]  unf;
    logic [1:0]  ovf;

    io_port_hub dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .addr_in  (addr_in),
        .io_in    (io_in),
        .out_en   (out_en),
        .addr_out (addr_out),
        .io_out   (io_out),
        .itr      (itr),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .unf      (unf),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic        ai;
        logic        oe;
        logic        ao;
        logic [15:0] iout;
        logic [31:0] sd;
        logic [1:0]  sv;
        logic [1:0]  mr;
        logic [15:0] e_io;
        logic        e_itr;
        logic [1:0]  e_sr;
        logic [31:0] e_md;
        logic [1:0]  e_mv;
        logic [1:0]  e_unf;
        logic [1:0]  e_ovf;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    function automatic vec_t mk(
        logic r, logic rq, logic ai, logic oe, logic ao, logic [15:0] iout,
        logic [15:0] sd1, logic [15:0] sd0, logic [1:0] sv, logic [1:0] mr,
        logic [15:0] e_io, logic e_itr, logic [1:0] e_sr,
        logic [15:0] e_md1, logic [15:0] e_md0, logic [1:0] e_mv,
        logic [1:0] e_unf, logic [1:0] e_ovf);
        vec_t v;
        v.rst = r;   v.req = rq;  v.ai = ai;  v.oe = oe;  v.ao = ao;
        v.iout = iout; v.sd = {sd1, sd0}; v.sv = sv; v.mr = mr;
        v.e_io = e_io; v.e_itr = e_itr; v.e_sr = e_sr; v.e_md = {e_md1, e_md0};
        v.e_mv = e_mv; v.e_unf = e_unf; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst      = v.rst;
        req_in   = v.req;
        addr_in  = v.ai;
        out_en   = v.oe;
        addr_out = v.ao;
        io_out   = v.iout;
        s_data   = v.sd;
        s_valid  = v.sv;
        m_ready  = v.mr;
        #1;
        chk("io_in",   idx, 32'(io_in),   32'(v.e_io));
        chk("itr",     idx, 32'(itr),     32'(v.e_itr));
        chk("s_ready", idx, 32'(s_ready), 32'(v.e_sr));
        chk("m_data",  idx, m_data,       v.e_md);
        chk("m_valid", idx, 32'(m_valid), 32'(v.e_mv));
        chk("unf",     idx, 32'(unf),     32'(v.e_unf));
        chk("ovf",     idx, 32'(ovf),     32'(v.e_ovf));
    endtask

    initial begin
        rst = 1'b0; req_in = 1'b0; addr_in = 1'b0; out_en = 1'b0; addr_out = 1'b0;
        io_out = '0; s_data = '0; s_valid = '0; m_ready = '0;

        //          rst rq ai oe ao iout     sd1      sd0      sv     mr     e_io     itr sr     md1      md0      mv     unf    ovf
        // reset state
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        // two pushes then two pops on ch0, itr rise/fall
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h1111, 2'b01, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h2222, 2'b01, 2'b00, 16'h1111, 0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h1111, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h2222, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        // six cycles of s_valid[1]: only four accepted
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'hA001, 16'h0,    2'b10, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'hA002, 16'h0,    2'b10, 2'b00, 16'hA001, 0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'hA003, 16'h0,    2'b10, 2'b00, 16'hA001, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'hA004, 16'h0,    2'b10, 2'b00, 16'hA001, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'hA005, 16'h0,    2'b10, 2'b00, 16'hA001, 1, 2'b01, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'hA006, 16'h0,    2'b10, 2'b00, 16'hA001, 1, 2'b01, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'hA001, 1, 2'b01, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'hA002, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'hA003, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'hA004, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        // pop on empty ch0, then push+pop on empty ch1
        tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0, 16'h3333, 16'h0,    2'b10, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h3333, 0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b11, 2'b00));
        tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h3333, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b11, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b11, 2'b00));
        // output ch0: write, dropped write, drain
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h00AB, 16'h0,  16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b11, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h00CD, 16'h0,  16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h00AB, 2'b01, 2'b11, 2'b00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b01, 16'h0,    0, 2'b11, 16'h0,    16'h00AB, 2'b01, 2'b11, 2'b01));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h00AB, 2'b00, 2'b11, 2'b01));
        // output ch1: back-to-back writes with m_ready held
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h0001, 16'h0,  16'h0,    2'b00, 2'b10, 16'h0,    0, 2'b11, 16'h0,    16'h00AB, 2'b00, 2'b11, 2'b01));
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h0002, 16'h0,  16'h0,    2'b00, 2'b10, 16'h0,    0, 2'b11, 16'h0001, 16'h00AB, 2'b10, 2'b11, 2'b01));
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h0003, 16'h0,  16'h0,    2'b00, 2'b10, 16'h0,    0, 2'b11, 16'h0002, 16'h00AB, 2'b10, 2'b11, 2'b01));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b10, 16'h0,    0, 2'b11, 16'h0003, 16'h00AB, 2'b10, 2'b11, 2'b01));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 16'h0,    16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0003, 16'h00AB, 2'b00, 2'b11, 2'b01));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Mid-stream asynchronous reset with 3 words buffered and m_valid[1] high
        apply(mk(1, 0, 0, 1, 1, 16'h0055, 16'h0, 16'h4441, 2'b01, 2'b00, 16'h0,    0, 2'b11, 16'h0003, 16'h00AB, 2'b00, 2'b11, 2'b01), 100);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h4442, 2'b01, 2'b00, 16'h4441, 0, 2'b11, 16'h0055, 16'h00AB, 2'b10, 2'b11, 2'b01), 101);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h4443, 2'b01, 2'b00, 16'h4441, 1, 2'b11, 16'h0055, 16'h00AB, 2'b10, 2'b11, 2'b01), 102);
        apply(mk(0, 0, 0, 0, 0, 16'h0,    16'h0, 16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 103);
        apply(mk(0, 0, 0, 0, 0, 16'h0,    16'h0, 16'h5555, 2'b01, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 104);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h5555, 2'b01, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 105);
        apply(mk(1, 1, 0, 0, 0, 16'h0,    16'h0, 16'h0,    2'b00, 2'b00, 16'h5555, 0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 106);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h0,    2'b00, 2'b00, 16'h0,    1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 107);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h0,    2'b00, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 108);

        // Push+pop on a non-empty, non-full channel keeps the count unchanged
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h6661, 2'b01, 2'b00, 16'h0,    0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 110);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h6662, 2'b01, 2'b00, 16'h6661, 0, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 111);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h6663, 2'b01, 2'b00, 16'h6661, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 112);
        apply(mk(1, 1, 0, 0, 0, 16'h0,    16'h0, 16'h6664, 2'b01, 2'b00, 16'h6661, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 113);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h6665, 2'b01, 2'b00, 16'h6662, 1, 2'b11, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 114);
        apply(mk(1, 0, 0, 0, 0, 16'h0,    16'h0, 16'h0,    2'b00, 2'b00, 16'h6662, 1, 2'b10, 16'h0,    16'h0,    2'b00, 2'b00, 2'b00), 115);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
